// File: rtl/mem_responder_if.sv
// Bus bundle between the datapath, the memory responder and the RAM model.
// The slave modport is the responder's view; master is the datapath/RAM side.
interface mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // datapath instruction port
  logic              imemREN;
  logic [ADDR_W-1:0] imemaddr;
  logic              ihit;
  logic [DATA_W-1:0] imemload;
  // datapath data port
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic              dhit;
  logic [DATA_W-1:0] dmemload;
  logic              halt;
  // RAM side
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              mem_err;

  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
           ramload, ramstate,
    output ihit, imemload, dhit, dmemload,
           ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
           ramload, ramstate,
    input  ihit, imemload, dhit, dmemload,
           ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// Arbitrates datapath fetch and data requests onto a single-ported RAM and
// returns one-cycle hit pulses; data has priority, with timeout and sticky error.
module mem_responder #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic            CLK,
  input  logic            RST,
  mem_responder_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DREQ = 2'd1;
  localparam logic [1:0] IREQ = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_reg,    state_next;
  logic [7:0]        tmo_cnt_reg,  tmo_cnt_next;
  logic              ren_reg,      ren_next;
  logic              wen_reg,      wen_next;
  logic [ADDR_W-1:0] ramaddr_reg,  ramaddr_next;
  logic [DATA_W-1:0] ramstore_reg, ramstore_next;
  logic              ihit_reg,     ihit_next;
  logic              dhit_reg,     dhit_next;
  logic [DATA_W-1:0] imemload_reg, imemload_next;
  logic [DATA_W-1:0] dmemload_reg, dmemload_next;
  logic              mem_err_reg,  mem_err_next;

  logic d_req;
  logic still_req;

  assign d_req = bus.dmemREN | bus.dmemWEN;
  // The originating request must still be present when ACCESS arrives,
  // otherwise the datapath has moved on and the result is discarded.
  assign still_req = (state_reg == DREQ) ? d_req : bus.imemREN;

  always_comb begin
    state_next    = state_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    ren_next      = ren_reg;
    wen_next      = wen_reg;
    ramaddr_next  = ramaddr_reg;
    ramstore_next = ramstore_reg;
    ihit_next     = 1'b0;
    dhit_next     = 1'b0;
    imemload_next = imemload_reg;
    dmemload_next = dmemload_reg;
    mem_err_next  = mem_err_reg;

    case (state_reg)
      IDLE: begin
        tmo_cnt_next = '0;
        if (d_req) begin
          ramaddr_next  = {bus.dmemaddr[ADDR_W-1:2], 2'b00};
          ramstore_next = bus.dmemstore;
          ren_next      = ~bus.dmemWEN;
          wen_next      = bus.dmemWEN;
          if ((bus.dmemREN && bus.dmemWEN) || (bus.dmemaddr[1:0] != 2'b00))
            mem_err_next = 1'b1;
          state_next = DREQ;
        end else if (bus.imemREN && !bus.halt) begin
          ramaddr_next = {bus.imemaddr[ADDR_W-1:2], 2'b00};
          ren_next     = 1'b1;
          wen_next     = 1'b0;
          if (bus.imemaddr[1:0] != 2'b00)
            mem_err_next = 1'b1;
          state_next = IREQ;
        end
      end

      DREQ, IREQ: begin
        tmo_cnt_next = tmo_cnt_reg + 8'd1;
        if (bus.ramstate == RS_ACCESS) begin
          ren_next   = 1'b0;
          wen_next   = 1'b0;
          state_next = DONE;
          if (still_req) begin
            if (state_reg == DREQ) begin
              dhit_next = 1'b1;
              if (!wen_reg)
                dmemload_next = bus.ramload;
            end else begin
              ihit_next     = 1'b1;
              imemload_next = bus.ramload;
            end
          end
        end else if ((bus.ramstate == RS_ERROR) || (tmo_cnt_reg == TMO_LAST)) begin
          ren_next     = 1'b0;
          wen_next     = 1'b0;
          mem_err_next = 1'b1;
          state_next   = DONE;
        end
      end

      // Turnaround cycle: gives the datapath one cycle to retire its request.
      DONE: begin
        tmo_cnt_next = '0;
        state_next   = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      tmo_cnt_reg  <= '0;
      ren_reg      <= 1'b0;
      wen_reg      <= 1'b0;
      ramaddr_reg  <= '0;
      ramstore_reg <= '0;
      ihit_reg     <= 1'b0;
      dhit_reg     <= 1'b0;
      imemload_reg <= '0;
      dmemload_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      ren_reg      <= ren_next;
      wen_reg      <= wen_next;
      ramaddr_reg  <= ramaddr_next;
      ramstore_reg <= ramstore_next;
      ihit_reg     <= ihit_next;
      dhit_reg     <= dhit_next;
      imemload_reg <= imemload_next;
      dmemload_reg <= dmemload_next;
      mem_err_reg  <= mem_err_next;
    end
  end

  assign bus.ramREN   = ren_reg;
  assign bus.ramWEN   = wen_reg;
  assign bus.ramaddr  = ramaddr_reg;
  assign bus.ramstore = ramstore_reg;
  assign bus.ihit     = ihit_reg;
  assign bus.dhit     = dhit_reg;
  assign bus.imemload = imemload_reg;
  assign bus.dmemload = dmemload_reg;
  assign bus.mem_err  = mem_err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table of transactions plus hand-built
// corner sequences; hit data is checked against a queue-based scoreboard.
module tb_mem_responder;

  logic CLK;
  logic RST;

  mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_responder #(.TIMEOUT_CYCLES(8), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] ram_mem [1024];
  int ram_busy = 0;
  int ram_mode = 0;   // 0 normal, 1 ERROR after busy, 2 never completes
  logic [31:0] last_dread;

  typedef struct {
    int          kind;     // 0 fetch, 1 data read, 2 data write
    logic [31:0] addr;
    logic [31:0] data;
    int          busy;
    bit          preload;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string p);
    chk({p, "_ihit"},     32'(bus.ihit),    32'd0);
    chk({p, "_dhit"},     32'(bus.dhit),    32'd0);
    chk({p, "_imemload"}, bus.imemload,     32'd0);
    chk({p, "_dmemload"}, bus.dmemload,     32'd0);
    chk({p, "_ramREN"},   32'(bus.ramREN),  32'd0);
    chk({p, "_ramWEN"},   32'(bus.ramWEN),  32'd0);
    chk({p, "_ramaddr"},  bus.ramaddr,      32'd0);
    chk({p, "_ramstore"}, bus.ramstore,     32'd0);
    chk({p, "_mem_err"},  32'(bus.mem_err), 32'd0);
  endtask

  // RAM model: counts strobe cycles, answers BUSY for ram_busy cycles, then ACCESS/ERROR.
  initial begin
    int cnt;
    cnt = 0;
    bus.ramstate = 2'b00;
    bus.ramload  = 32'd0;
    for (int i = 0; i < 1024; i++) ram_mem[i] = 32'hA5A5_0000 | 32'(i);
    forever begin
      @(negedge CLK);
      if (bus.ramREN || bus.ramWEN) begin
        cnt++;
        if (ram_mode == 2 || cnt <= ram_busy) begin
          bus.ramstate = 2'b01;
        end else if (ram_mode == 1) begin
          bus.ramstate = 2'b11;
        end else begin
          bus.ramstate = 2'b10;
          if (bus.ramREN) bus.ramload = ram_mem[bus.ramaddr[11:2]];
          if (bus.ramWEN) ram_mem[bus.ramaddr[11:2]] = bus.ramstore;
        end
      end else begin
        cnt = 0;
        bus.ramstate = 2'b00;
      end
    end
  end

  // Scoreboard monitor: every hit pops one expected word.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (bus.ihit && bus.dhit) begin
          checks++; errors++;
          $display("FAIL hit_overlap actual=both required=one");
        end
        if (bus.ihit) begin
          if (iq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ihit actual=1 required=0");
          end else begin
            e = iq.pop_front();
            chk("imemload", bus.imemload, e);
          end
        end
        if (bus.dhit) begin
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_dhit actual=1 required=0");
          end else begin
            e = dq.pop_front();
            chk("dmemload", bus.dmemload, e);
          end
        end
      end
    end
  end

  task automatic txn(input logic ir, input logic dr, input logic dw,
                     input logic [31:0] a, input logic [31:0] s,
                     input int busy, input int mode, input logic exp_hit,
                     input logic [31:0] exp_data, input int exp_strobe,
                     input logic exp_err, input logic withdraw, input string nm);
    int strobes;
    int lat;
    logic got_hit;
    logic first;
    ram_busy = busy;
    ram_mode = mode;
    if (exp_hit) begin
      if (ir) iq.push_back(exp_data);
      else    dq.push_back(exp_data);
    end
    @(negedge CLK);
    bus.imemREN = ir; bus.dmemREN = dr; bus.dmemWEN = dw;
    bus.imemaddr = a; bus.dmemaddr = a; bus.dmemstore = s;
    strobes = 0; lat = 0; got_hit = 1'b0; first = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (bus.ramREN || bus.ramWEN) begin
        strobes++;
        if (first) begin
          first = 1'b0;
          chk({nm, "_ramaddr"}, bus.ramaddr, {a[31:2], 2'b00});
          chk({nm, "_ramWEN"}, 32'(bus.ramWEN), 32'(dw));
          chk({nm, "_ramREN"}, 32'(bus.ramREN), 32'(!dw));
          if (dw) chk({nm, "_ramstore"}, bus.ramstore, s);
          if (withdraw) begin bus.dmemREN = 1'b0; bus.imemREN = 1'b0; end
        end
      end
      if (bus.ihit || bus.dhit) begin got_hit = 1'b1; lat = c; end
      if (got_hit || (strobes > 0 && !(bus.ramREN || bus.ramWEN))) break;
    end
    bus.imemREN = 1'b0; bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0;
    chk({nm, "_strobe_cycles"}, 32'(strobes), 32'(exp_strobe));
    chk({nm, "_hit"}, 32'(got_hit), 32'(exp_hit));
    if (exp_hit) chk({nm, "_latency"}, 32'(lat), 32'(exp_strobe + 1));
    else if (!ir && !dw) chk({nm, "_dmemload_kept"}, bus.dmemload, exp_data);
    chk({nm, "_mem_err"}, 32'(bus.mem_err), 32'(exp_err));
    $display("txn %-12s addr=0x%08h strobes=%0d hit=%0b mem_err=%0b",
             nm, a, strobes, got_hit, bus.mem_err);
  endtask

  task automatic pulse_reset();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_d, seen_i, d_first, addr_checked;
    int halt_strobes;

    vecs[0] = '{0, 32'h0000_0040, 32'h2001_0005, 3, 1'b1};
    vecs[1] = '{1, 32'h0000_0100, 32'h1234_5678, 1, 1'b1};
    vecs[2] = '{2, 32'h0000_0200, 32'hDEAD_BEEF, 0, 1'b0};
    vecs[3] = '{1, 32'h0000_0200, 32'hDEAD_BEEF, 2, 1'b0};
    vecs[4] = '{0, 32'h0000_0044, 32'h0BAD_C0DE, 0, 1'b1};
    vecs[5] = '{2, 32'h0000_0208, 32'h0000_55AA, 4, 1'b0};
    vecs[6] = '{1, 32'h0000_0104, 32'hCAFE_F00D, 5, 1'b1};

    RST = 1'b1;
    bus.imemREN = 1'b0; bus.imemaddr = '0; bus.halt = 1'b0;
    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.dmemaddr = '0; bus.dmemstore = '0;
    last_dread = 32'd0;
    @(negedge CLK);
    check_zero("reset");
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].preload) ram_mem[vecs[i].addr[11:2]] = vecs[i].data;
      case (vecs[i].kind)
        0: txn(1'b1, 1'b0, 1'b0, vecs[i].addr, 32'd0, vecs[i].busy, 0, 1'b1,
               vecs[i].data, vecs[i].busy + 1, 1'b0, 1'b0, $sformatf("vec%0d_fetch", i));
        1: begin
          txn(1'b0, 1'b1, 1'b0, vecs[i].addr, 32'd0, vecs[i].busy, 0, 1'b1,
              vecs[i].data, vecs[i].busy + 1, 1'b0, 1'b0, $sformatf("vec%0d_read", i));
          last_dread = vecs[i].data;
        end
        default: txn(1'b0, 1'b0, 1'b1, vecs[i].addr, vecs[i].data, vecs[i].busy, 0, 1'b1,
                     last_dread, vecs[i].busy + 1, 1'b0, 1'b0, $sformatf("vec%0d_write", i));
      endcase
    end

    // Fetch and data raised together: data must be served first.
    ram_mem[32'h100 >> 2] = 32'h1111_0100;
    ram_mem[32'h080 >> 2] = 32'h2222_0080;
    ram_busy = 1; ram_mode = 0;
    dq.push_back(32'h1111_0100);
    iq.push_back(32'h2222_0080);
    @(negedge CLK);
    bus.imemREN = 1'b1; bus.imemaddr = 32'h80;
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100;
    seen_d = 0; seen_i = 0; d_first = 0; addr_checked = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (bus.ramREN && !addr_checked) begin
        chk("prio_first_ramaddr", bus.ramaddr, 32'h100);
        addr_checked = 1;
      end
      if (bus.dhit) begin if (!seen_i) d_first = 1; seen_d = 1; bus.dmemREN = 1'b0; end
      if (bus.ihit) begin seen_i = 1; bus.imemREN = 1'b0; end
      if (seen_d && seen_i) break;
    end
    bus.imemREN = 1'b0; bus.dmemREN = 1'b0;
    chk("prio_both_hits", {30'd0, seen_d, seen_i}, 32'd3);
    chk("prio_data_first", 32'(d_first), 32'd1);
    $display("txn %-12s dhit=%0b ihit=%0b data_first=%0b", "priority", seen_d, seen_i, d_first);
    last_dread = 32'h1111_0100;

    // Halt blocks fetches but data is still served.
    @(negedge CLK);
    bus.halt = 1'b1; bus.imemREN = 1'b1; bus.imemaddr = 32'h40;
    halt_strobes = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (bus.ramREN || bus.ramWEN) halt_strobes++;
    end
    chk("halt_no_fetch_strobe", 32'(halt_strobes), 32'd0);
    $display("txn %-12s strobes=%0d", "halt_fetch", halt_strobes);
    bus.imemREN = 1'b0;
    ram_mem[32'h180 >> 2] = 32'h0180_0180;
    txn(1'b0, 1'b1, 1'b0, 32'h180, 32'd0, 0, 0, 1'b1, 32'h0180_0180, 1, 1'b0, 1'b0, "halt_dread");
    last_dread = 32'h0180_0180;
    bus.halt = 1'b0;

    // Withdrawn read: access completes, no hit, load kept.
    txn(1'b0, 1'b1, 1'b0, 32'h400, 32'd0, 3, 0, 1'b0, last_dread, 4, 1'b0, 1'b1, "withdraw");

    // RAM ERROR response.
    txn(1'b0, 1'b1, 1'b0, 32'h500, 32'd0, 1, 1, 1'b0, last_dread, 2, 1'b1, 1'b0, "ram_error");

    // Reset in the middle of a data transaction.
    ram_mode = 2;
    @(negedge CLK);
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h700;
    @(negedge CLK);
    chk("rst_pre_ramREN", 32'(bus.ramREN), 32'd1);
    #2 RST = 1'b1;
    #1 chk("rst_async_ramREN", 32'(bus.ramREN), 32'd0);
    bus.dmemREN = 1'b0;
    @(negedge CLK);
    check_zero("midrst");
    RST = 1'b0;
    ram_mode = 0;
    last_dread = 32'd0;
    $display("txn %-12s addr=0x%08h", "mid_reset", 32'h700);

    // REN and WEN together: handled as a write and flagged.
    txn(1'b0, 1'b1, 1'b1, 32'h600, 32'h0000_1234, 0, 0, 1'b1, last_dread, 1, 1'b1, 1'b0, "ren_and_wen");

    // Misaligned read proceeds word-aligned and is flagged.
    pulse_reset();
    ram_mem[32'h700 >> 2] = 32'h7070_7070;
    txn(1'b0, 1'b1, 1'b0, 32'h702, 32'd0, 1, 0, 1'b1, 32'h7070_7070, 2, 1'b1, 1'b0, "misaligned");

    // Timeout after 8 BUSY cycles, then a normal read still completes.
    pulse_reset();
    last_dread = 32'd0;
    txn(1'b0, 1'b1, 1'b0, 32'h300, 32'd0, 0, 2, 1'b0, last_dread, 8, 1'b1, 1'b0, "timeout");
    ram_mem[32'h304 >> 2] = 32'h3030_3030;
    txn(1'b0, 1'b1, 1'b0, 32'h304, 32'd0, 1, 0, 1'b1, 32'h3030_3030, 2, 1'b1, 1'b0, "post_timeout");

    @(negedge CLK);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
